// File: rtl/lab62_pio_pkg.sv
// Shared constants for the lab62 edge-capture input PIO: register offsets and edge-type encodings.
package lab62_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab62_pio_debounce.sv
// Single-bit 2-FF synchroniser followed by an optional stable-count debouncer.
module lab62_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign dout = s2;
    end else begin : g_debounce
      logic             stable;
      logic [CNT_W-1:0] cnt;

      // A change is accepted on its Nth consecutive differing cycle; any return clears the count.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          stable <= 1'b0;
          cnt    <= '0;
        end else if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign dout = stable;
    end
  endgenerate

endmodule

// File: rtl/lab62_pio_edge_irq.sv
// Avalon-MM input PIO: per-channel sync/debounce, edge capture flags, maskable level IRQ.
module lab62_pio_edge_irq
  import lab62_pio_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int EDGE_MODE       = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, prev, edge_evt, edge_capture, irq_mask, cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      lab62_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[g]),
        .dout   (stable[g])
      );
    end
  endgenerate

  always_comb begin
    case (EDGE_MODE)
      EDGE_RISE: edge_evt = stable & ~prev;
      EDGE_FALL: edge_evt = ~stable & prev;
      default:   edge_evt = stable ^ prev;
    endcase
  end

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      prev <= stable;
      if (wr_en && address == ADDR_IRQ_MASK)
        irq_mask <= writedata[WIDTH-1:0];
      // A new event outranks a same-cycle clear so no edge is lost.
      edge_capture <= (edge_capture & ~cap_clr) | edge_evt;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= rd_mux;
    end
  end

endmodule

// File: tb/tb_lab62_pio_edge_irq.sv
// Directed bench: three PIO instances (rise/N=0, rise/N=4, fall/N=0) on a shared Avalon bus.
module tb_lab62_pio_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0, in_c = '0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab62_pio_edge_irq #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(0), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  lab62_pio_edge_irq #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  lab62_pio_edge_irq #(.WIDTH(8), .EDGE_MODE(1), .DEBOUNCE_CYCLES(0), .CNT_W(16)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = (sel == 0);
    cs_b      = (sel == 1);
    cs_c      = (sel == 2);
    tick();
    write_n = 1'b1;
    cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
    reset_n = 1'b1;
    bus_rd(2'd3);
    chk("rst_cap_a", rd_a, 32'h0);
    chk("rst_cap_b", rd_b, 32'h0);

    // rising capture latency, N=0
    in_a = 8'h05;
    repeat (3) tick();
    chk("a_cap_early", rd_a, 32'h0);
    tick();
    chk("a_cap_05", rd_a, 32'h05);
    chk("a_irq_masked", {31'b0, irq_a}, 32'h0);

    bus_wr(0, 2'd2, 32'h04);
    chk("a_irq_same", {31'b0, irq_a}, 32'h0);
    tick();
    chk("a_irq_mask_on", {31'b0, irq_a}, 32'h1);
    chk("a_mask_rd", rd_a, 32'h04);

    bus_rd(2'd0);
    chk("a_data", rd_a, 32'h05);
    bus_wr(0, 2'd0, 32'hFF);
    bus_rd(2'd0);
    chk("a_data_ro", rd_a, 32'h05);
    bus_wr(0, 2'd1, 32'hFF);
    bus_rd(2'd1);
    chk("a_rsvd", rd_a, 32'h0);

    // write-1-clear and irq drop
    bus_wr(0, 2'd2, 32'h01);
    tick();
    chk("a_irq_b0", {31'b0, irq_a}, 32'h1);
    bus_wr(0, 2'd3, 32'h01);
    chk("a_irq_hold", {31'b0, irq_a}, 32'h1);
    tick();
    chk("a_irq_drop", {31'b0, irq_a}, 32'h0);
    bus_rd(2'd3);
    chk("a_cap_w1c", rd_a, 32'h04);
    bus_wr(0, 2'd3, 32'h00);
    bus_rd(2'd3);
    chk("a_cap_w0", rd_a, 32'h04);

    // event on bit1 lands on the same edge as its clear
    in_a = 8'h07;
    repeat (2) tick();
    bus_wr(0, 2'd3, 32'h06);
    bus_rd(2'd3);
    chk("a_set_wins", rd_a, 32'h02);

    // falling edge ignored in rising mode
    bus_wr(0, 2'd3, 32'hFF);
    in_a = 8'h03;
    repeat (4) tick();
    bus_rd(2'd3);
    chk("a_no_fall", rd_a, 32'h0);

    // debounce N=4: 3-cycle glitch rejected
    bus_wr(1, 2'd2, 32'h01);
    in_b = 8'h01;
    repeat (3) tick();
    in_b = 8'h00;
    repeat (6) tick();
    bus_rd(2'd0);
    chk("b_glitch_data", rd_b, 32'h0);
    bus_rd(2'd3);
    chk("b_glitch_cap", rd_b, 32'h0);
    chk("b_glitch_irq", {31'b0, irq_b}, 32'h0);

    // 4-cycle hold accepted: stable at k+5, irq at k+7
    address = 2'd0;
    in_b = 8'h01;
    repeat (6) tick();
    chk("b_data_early", rd_b, 32'h0);
    tick();
    chk("b_data_on", rd_b, 32'h01);
    chk("b_irq_early", {31'b0, irq_b}, 32'h0);
    tick();
    chk("b_irq_on", {31'b0, irq_b}, 32'h1);
    bus_rd(2'd3);
    chk("b_cap_01", rd_b, 32'h01);

    // mid-debounce reset with everything set
    in_b = 8'hFF;
    repeat (10) tick();
    bus_wr(1, 2'd2, 32'hFF);
    tick();
    bus_rd(2'd3);
    chk("b_cap_ff", rd_b, 32'hFF);
    chk("b_irq_ff", {31'b0, irq_b}, 32'h1);
    in_b = 8'h7F;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("b_rst_rd", rd_b, 32'h0);
    chk("b_rst_irq", {31'b0, irq_b}, 32'h0);
    bus_rd(2'd2);
    chk("b_rst_mask", rd_b, 32'h0);
    bus_rd(2'd3);
    chk("b_rst_cap", rd_b, 32'h0);
    bus_rd(2'd0);
    chk("b_rst_data", rd_b, 32'h0);
    repeat (12) tick();
    bus_rd(2'd3);
    chk("b_held_cap", rd_b, 32'h7F);
    chk("a_held_cap", rd_a, 32'h03);
    bus_rd(2'd0);
    chk("b_held_data", rd_b, 32'h7F);
    chk("b_held_irq", {31'b0, irq_b}, 32'h0);

    // falling mode
    in_c = 8'h08;
    repeat (5) tick();
    bus_rd(2'd3);
    chk("c_no_rise", rd_c, 32'h0);
    in_c = 8'h04;
    repeat (5) tick();
    bus_rd(2'd3);
    chk("c_fall_08", rd_c, 32'h08);
    chk("c_irq", {31'b0, irq_c}, 32'h0);
    bus_wr(2, 2'd3, 32'h08);
    bus_rd(2'd3);
    chk("c_clr", rd_c, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab62_pio_edge_irq.md
Name:
lab62_pio_edge_irq

Overview:
Parametrised Avalon-MM input PIO, the successor to the single-bit edge-capture PIO on the lab62 SoC bus. Each of WIDTH input channels is synchronised, optionally debounced, and edge-detected with a selectable edge type. Events latch into per-bit capture flags. A maskable, level-sensitive IRQ goes to the Nios II interrupt controller. Serves switches and keys: accumulate, reset, run.

Parameters:
WIDTH, 1, number of input channels (1..32)
EDGE_MODE, 2, 0 = rising, 1 = falling, 2 = any edge (one value for all channels)
DEBOUNCE_CYCLES, 0, consecutive stable cycles before a change is accepted; 0 bypasses the debouncer
CNT_W, 16, debounce counter width; DEBOUNCE_CYCLES must not exceed 2^CNT_W-1

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  reset; synchronous, active-low
address  in  2  Avalon word offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data, zero-extended above WIDTH
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  registered interrupt request, active-high level

Behaviour:
- Reset: single clock domain on clk; reset is synchronous, active-low (reset_n sampled on posedge clk). Low clears readdata, irq, sync FFs, debounced value, counters, prev value, irq_mask and edge_capture to 0. Mid-operation reset aborts debounce counts and discards pending captures.
- Input path per bit: 2-FF synchroniser (s1, s2), then debouncer, then edge detector.
- Debounce, N = DEBOUNCE_CYCLES:
  - N = 0: stable = s2, combinational.
  - N > 0: counter clears whenever s2 == stable. When they differ, counter increments each cycle. When s2 differs from stable on the cycle counter == N-1, stable <= s2 and counter clears.
  - A glitch shorter than N cycles leaves stable unchanged.
- Edge detect: prev <= stable every cycle.
  - Rising: stable & ~prev.
  - Falling: ~stable & prev.
  - Any: stable ^ prev.
- Latency: in_port changes before clk edge k. edge_capture bit is set at edge k+2+N. irq rises at edge k+3+N (when that bit is unmasked).
- Register map, word offsets:
  - 0 DATA: RO; reads the debounced stable vector. Writes are ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits. Bit = 1 enables that channel's interrupt.
  - 3 EDGE_CAPTURE: reads the capture flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Write strobe: chipselect & ~write_n at the decoded address. Writes take effect at the next edge.
- Simultaneous event and clear on the same bit in the same cycle: set wins, so no event is lost. Other bits are cleared normally.
- readdata: registered every cycle from the address-selected source, independent of chipselect (read latency 1). Bits above WIDTH read 0.
- irq <= |(edge_capture & irq_mask), registered.
  - Clearing the capture bit or the mask bit drops irq one cycle after the register updates.
  - Setting a mask bit while its capture bit is already set asserts irq.
- Power-up / reset with an input held high: after reset, stable goes 0 -> 1 following sync plus debounce, so rising/any modes capture one edge. Software clears it at init.
- Counter saturation cannot occur: counter never exceeds N-1.

Decomposition:
- Package lab62_pio_pkg holds:
  - register offset constants: ADDR_DATA = 0, ADDR_IRQ_MASK = 2, ADDR_EDGE_CAP = 3
  - EDGE_MODE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY
- One sub-module, lab62_pio_debounce, is generated WIDTH times. It contains the single-bit synchroniser plus debouncer and is parameterised by DEBOUNCE_CYCLES and CNT_W. Ports: clk, reset_n, din, dout.
- Edge detect, capture, mask, read mux and irq stay in the top level.

Test Plan:
1. WIDTH=8, N=0, EDGE_MODE=0: drive in_port 8'h00 -> 8'h05 at edge k -> EDGE_CAPTURE reads 8'h05 from edge k+2; irq stays 0 (mask 0). Write IRQ_MASK=8'h04 -> irq=1 one cycle after the mask updates.
2. N=4: 3-cycle pulse on bit 0 -> DATA and EDGE_CAPTURE unchanged (0). 4-cycle hold -> DATA bit0=1 at edge k+5; capture bit0 set at edge k+6.
3. EDGE_MODE=1 (falling): bit 3 goes 1 -> 0 -> capture 8'h08. A rising transition on bit 2 produces no capture.
4. Write EDGE_CAPTURE=8'h01 while captures are 8'h03 -> reads 8'h02; irq drops if only bit0 was unmasked. Write 8'h00 -> no change.
5. Same-cycle write-1-clear of bit 1 and new edge on bit 1 -> bit 1 remains 1 afterwards.
6. Assert reset_n=0 for one edge mid-debounce (counter=2) with captures 8'hFF and mask 8'hFF -> all registers 0, irq=0, readdata=0. A held-high input then captures one rising edge after 2+N cycles.
